sample_feeder: RTL and testbench
================================

# sample_feeder

Upstream stage of the perceptron classifier. Accepts 8-bit input samples over a valid/ready handshake and buffers them in a small FIFO. Presents each sample on a stable `current` bus for exactly one 8-cycle bit-serial frame, with frame markers and a bit-slot index so the downstream perceptron can align its bit walk. Back-to-back frames run gap-free while samples are queued.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of 2, at least 2.
- `HOLD`, default 8: cycles each sample is held; equals the sample width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset. Clock is `clk`. Reset is asynchronous and active-high.
- `in_data`  in  8: sample from the source.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: FIFO can accept; equals `!full`.
- `current`  out  8: sample under presentation; feeds the perceptron `current` input.
- `frame_start`  out  1: one-cycle pulse in the first cycle of each frame.
- `frame_active`  out  1: high for all `HOLD` cycles of a frame.
- `slot`  out  3: bit index within the frame, 0..`HOLD-1`; 0 when idle.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy, 0..`DEPTH`.
- `frame_count`  out  8: completed frames, wrapping.

## Operation
- Push: `in_valid && in_ready` at an edge writes `in_data` at `wr_ptr`, and `wr_ptr` increments modulo `DEPTH`.
- Pop: performed by the FSM; reads at `rd_ptr`, and `rd_ptr` increments modulo `DEPTH`.
- Occupancy:
  - Push and pop on the same edge: `level` is unchanged.
  - When full, `in_ready`=0 and `in_valid` is ignored; no overwrite.
  - A push into a full FIFO is impossible by construction.
- FSM states IDLE and HOLD.
  - IDLE, `level`>0: pop into the `current` register, `slot`<=0, `frame_start`<=1, go to HOLD.
  - IDLE, `level`=0: stay; `current` keeps its last value; `frame_active`=0.
  - HOLD, `slot`<`HOLD-1`: `slot`<=`slot`+1, `frame_start`<=0.
  - HOLD, `slot`=`HOLD-1`: `frame_count`<=`frame_count`+1, wrapping 255->0.
    - If `level`>0: pop the next sample, `slot`<=0, `frame_start`<=1, stay in HOLD (no gap).
    - Otherwise: go to IDLE, `slot`<=0.
- A pop uses the `level` value before the current edge. A sample pushed on the same edge is not visible to that pop decision.
- `frame_active` = (state==HOLD).
- Reset value of every output:
  - `current`=0x00, `frame_start`=0, `frame_active`=0, `slot`=0, `level`=0, `frame_count`=0.
  - `in_ready`=1.
  - Pointers are cleared. Pushes are ignored while `rst` is high.
- Reset mid-frame: the frame is abandoned, outputs return to reset values immediately (asynchronous), and FIFO contents are discarded.

## Timing
- Latency from idle: sample accepted at edge k gives `current`, `frame_start`=1, `slot`=0, `frame_active`=1 after edge k+1.
- Frame length: exactly `HOLD` cycles; `slot` runs 0..7 across them.
- `current` is stable for the whole frame and changes only on a frame-start edge.
- Back-to-back frames: `frame_start` pulses every `HOLD` cycles with no idle cycle between frames.
- `in_ready` is derived from registered `level` only; there is no combinational path from `in_valid`.
- The frame-completion increment of `frame_count` happens on the edge that leaves `slot`=`HOLD-1`.

## Test plan
- Reset then single push of 0xA5 at edge 1:
  - after edge 2, `current`=0xA5, `frame_start`=1 for one cycle;
  - `slot` counts 0..7;
  - IDLE after edge 10;
  - `frame_count`=1.
- Burst of pushes 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive edges with `in_valid` held:
  - `in_ready` drops when `level`=4;
  - all five are presented in order, each for 8 cycles;
  - `frame_start` pulses every 8 cycles with no gap;
  - none are lost.
- Full FIFO, then push attempted on the same edge the FSM pops:
  - push rejected (`in_ready`=0 before the edge);
  - next cycle `level`=3 and `in_ready`=1.
- Simultaneous push and pop at a frame boundary with `level`=1:
  - `level` stays 1;
  - the new frame shows the older sample.
- Assert `rst` asynchronously at `slot`=4 with 2 samples queued:
  - all outputs return to reset values immediately, including `current`=0x00, `level`=0, `frame_active`=0;
  - the first push after release is presented after the following edge.
- Run 256 frames: `frame_count` wraps to 0x00 after the 256th completion.

Source files
------------

// File: rtl/sample_feeder.sv
// Sample FIFO and frame sequencer: buffers 8-bit samples and presents each one on
// `current` for one HOLD-cycle bit-serial frame, with frame markers and a slot index.
module sample_feeder #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               current,
  output logic                     frame_start,
  output logic                     frame_active,
  output logic [2:0]               slot,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [2:0]    LAST_SLOT = 3'(HOLD - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [7:0]      r_current;
  logic            r_frame_start;
  logic [2:0]      r_slot;
  logic [7:0]      r_frame_count;

  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_frame_done;
  logic            w_frame_start_nxt;
  logic [2:0]      w_slot_nxt;
  logic            w_have_sample;

  // Ready depends only on registered occupancy, never on in_valid.
  assign w_ready       = (r_level != FULL_LVL);
  assign w_push        = in_valid && w_ready && !rst;
  assign w_have_sample = (r_level != '0);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt       = r_state;
    w_slot_nxt        = r_slot;
    w_frame_start_nxt = 1'b0;
    w_pop             = 1'b0;
    w_frame_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_have_sample) begin
          w_pop             = 1'b1;
          w_slot_nxt        = 3'd0;
          w_frame_start_nxt = 1'b1;
          w_state_nxt       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_slot != LAST_SLOT) begin
          w_slot_nxt = r_slot + 3'd1;
        end else begin
          w_frame_done = 1'b1;
          w_slot_nxt   = 3'd0;
          if (w_have_sample) begin
            w_pop             = 1'b1;
            w_frame_start_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_slot_nxt  = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_slot        <= 3'd0;
      r_frame_start <= 1'b0;
      r_current     <= 8'h00;
      r_frame_count <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_frame_start <= w_frame_start_nxt;
      if (w_pop) begin
        r_current <= r_mem[r_rd_ptr];
      end
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; cleared pointers and level make any
  // stale contents unreachable, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign in_ready     = w_ready;
  assign current      = r_current;
  assign frame_start  = r_frame_start;
  assign frame_active = (r_state == S_HOLD);
  assign slot         = r_slot;
  assign level        = r_level;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: a per-cycle vector table for a single frame,
// then hand-written sequences for bursts, full-FIFO, boundary push/pop, reset and wrap.
module tb_sample_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] current;
  logic       frame_start;
  logic       frame_active;
  logic [2:0] slot;
  logic [2:0] level;
  logic [7:0] frame_count;

  sample_feeder #(.DEPTH(4), .HOLD(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .current      (current),
    .frame_start  (frame_start),
    .frame_active (frame_active),
    .slot         (slot),
    .level        (level),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [7:0] cur;
    logic       fs;
    logic       fa;
    logic [2:0] slt;
    logic [2:0] lvl;
    logic       rdy;
    logic [7:0] fc;
  } vec_t;

  vec_t       tbl [10];
  int         n_checks;
  int         n_fail;
  int         cyc;
  bit         rec_en;
  logic [7:0] fq_val [$];
  int         fq_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge, then settle away from the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rec_en && frame_start) begin
      fq_val.push_back(current);
      fq_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_slot(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (frame_active && slot == s) break;
      step();
    end
    check(name, 32'(frame_active && slot == s), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      step();
      if (!frame_active) break;
    end
    check(name, 32'(frame_active), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rec_en   = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Single sample 0xA5: one frame of eight slots, then idle.
    tbl[0] = '{vld: 1'b1, data: 8'hA5, cur: 8'h00, fs: 1'b0, fa: 1'b0, slt: 3'd0, lvl: 3'd1, rdy: 1'b1, fc: 8'd0};
    tbl[1] = '{vld: 1'b0, data: 8'h00, cur: 8'hA5, fs: 1'b1, fa: 1'b1, slt: 3'd0, lvl: 3'd0, rdy: 1'b1, fc: 8'd0};
    for (int i = 2; i <= 8; i++)
      tbl[i] = '{vld: 1'b0, data: 8'h00, cur: 8'hA5, fs: 1'b0, fa: 1'b1, slt: 3'(i - 1), lvl: 3'd0, rdy: 1'b1, fc: 8'd0};
    tbl[9] = '{vld: 1'b0, data: 8'h00, cur: 8'hA5, fs: 1'b0, fa: 1'b0, slt: 3'd0, lvl: 3'd0, rdy: 1'b1, fc: 8'd1};

    #12;
    check("rst_current", 32'(current), 32'h00);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].data;
      step();
      check($sformatf("v%0d_current", i), 32'(current), 32'(tbl[i].cur));
      check($sformatf("v%0d_frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
      check($sformatf("v%0d_frame_active", i), 32'(frame_active), 32'(tbl[i].fa));
      check($sformatf("v%0d_slot", i), 32'(slot), 32'(tbl[i].slt));
      check($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      check($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].fc));
    end

    // Burst of five, then a push held against a full FIFO across the pop edge.
    begin
      int exp_lvl [5] = '{1, 1, 2, 3, 4};
      int exp_rdy [5] = '{1, 1, 1, 1, 0};
      fq_val.delete();
      fq_cyc.delete();
      rec_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        in_data  = 8'(i + 1);
        step();
        check($sformatf("burst%0d_level", i), 32'(level), 32'(exp_lvl[i]));
        check($sformatf("burst%0d_in_ready", i), 32'(in_ready), 32'(exp_rdy[i]));
      end
      in_data = 8'h77;
      wait_slot(3'd7, 12, "full_wait_slot7");
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_level", 32'(level), 32'd4);
      step();
      in_valid = 1'b0;
      check("after_pop_level", 32'(level), 32'd3);
      check("after_pop_in_ready", 32'(in_ready), 32'd1);
      check("after_pop_current", 32'(current), 32'h02);
      wait_idle(60, "burst_drain");
      rec_en = 1'b0;
      check("burst_frames", 32'(fq_val.size()), 32'd5);
      for (int i = 0; i < fq_val.size() && i < 5; i++) begin
        check($sformatf("burst_frame%0d_value", i), 32'(fq_val[i]), 32'(i + 1));
        if (i > 0)
          check($sformatf("burst_frame%0d_gap", i), 32'(fq_cyc[i] - fq_cyc[i-1]), 32'd8);
      end
      check("burst_level_end", 32'(level), 32'd0);
      check("burst_frame_count", 32'(frame_count), 32'd6);
    end

    // Push and pop on the same frame-boundary edge with one sample queued.
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_valid = 1'b0;
    step();
    check("bnd_first_current", 32'(current), 32'h11);
    in_valid = 1'b1;
    in_data  = 8'h22;
    step();
    in_valid = 1'b0;
    check("bnd_level_before", 32'(level), 32'd1);
    wait_slot(3'd7, 12, "bnd_wait_slot7");
    in_valid = 1'b1;
    in_data  = 8'h33;
    step();
    in_valid = 1'b0;
    check("bnd_level", 32'(level), 32'd1);
    check("bnd_current", 32'(current), 32'h22);
    check("bnd_frame_start", 32'(frame_start), 32'd1);
    check("bnd_slot", 32'(slot), 32'd0);
    wait_idle(40, "bnd_drain");
    check("bnd_last_current", 32'(current), 32'h33);
    check("bnd_frame_count", 32'(frame_count), 32'd9);

    // Asynchronous reset at slot 4 with two samples queued.
    in_valid = 1'b1;
    in_data  = 8'hB1;
    step();
    in_data  = 8'hB2;
    step();
    in_data  = 8'hB3;
    step();
    in_valid = 1'b0;
    wait_slot(3'd4, 12, "rst_wait_slot4");
    check("pre_rst_level", 32'(level), 32'd2);
    check("pre_rst_current", 32'(current), 32'hB1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_current", 32'(current), 32'h00);
    check("arst_level", 32'(level), 32'd0);
    check("arst_frame_active", 32'(frame_active), 32'd0);
    check("arst_frame_start", 32'(frame_start), 32'd0);
    check("arst_slot", 32'(slot), 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    check("push_in_rst_level", 32'(level), 32'd0);
    rst     = 1'b0;
    in_data = 8'hC4;
    step();
    in_valid = 1'b0;
    check("post_rst_level", 32'(level), 32'd1);
    check("post_rst_idle", 32'(frame_active), 32'd0);
    step();
    check("post_rst_current", 32'(current), 32'hC4);
    check("post_rst_frame_start", 32'(frame_start), 32'd1);
    check("post_rst_level_pop", 32'(level), 32'd0);
    wait_idle(20, "post_rst_drain");

    // 256 back-to-back frames: frame_count wraps on the 256th completion.
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 2049; i++) step();
    check("wrap_pre_count", 32'(frame_count), 32'd255);
    check("wrap_pre_slot", 32'(slot), 32'd7);
    step();
    check("wrap_count", 32'(frame_count), 32'd0);
    check("wrap_frame_start", 32'(frame_start), 32'd1);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
